// File: rtl/counter_32_ctrl_pkg.sv
// rtl/counter_32_ctrl_pkg.sv - shared state type and terminal-count constants for counter_32_ctrl
package counter_32_ctrl_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TERM_UP = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TERM_DN = {CNT_W{1'b0}};

endpackage

// File: rtl/counter_32_ctrl_irq.sv
// rtl/counter_32_ctrl_irq.sv - done pulse, sticky irq and optional expiry count
// Optional expiry counter enabled by COUNTER_32_CTRL_EXPCNT_EN.
module counter_32_ctrl_irq
`ifdef COUNTER_32_CTRL_EXPCNT_EN
#(
  parameter int unsigned ECNT_W = 8
)
`endif
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rc_valid_i,
  input  logic              irq_clr_i,
`ifdef COUNTER_32_CTRL_EXPCNT_EN
  input  logic              start_i,
  output logic [ECNT_W-1:0] exp_cnt_o,
`endif
  output logic              done_o,
  output logic              irq_o
);

  logic done_q, done_d;
  logic irq_q, irq_d;

  // An expiry in the same cycle as irq_clr must not be lost.
  assign done_d = rc_valid_i;
  assign irq_d  = rc_valid_i | (irq_q & ~irq_clr_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      irq_q  <= irq_d;
    end
  end

  assign done_o = done_q;
  assign irq_o  = irq_q;

`ifdef COUNTER_32_CTRL_EXPCNT_EN
  logic [ECNT_W-1:0] exp_q, exp_d;

  always_comb begin
    exp_d = exp_q;
    if (start_i) begin
      exp_d = '0;
    end else if (rc_valid_i && (exp_q != {ECNT_W{1'b1}})) begin
      exp_d = exp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_cnt_o = exp_q;
`endif

endmodule

// File: rtl/counter_32_ctrl.sv
// rtl/counter_32_ctrl.sv - start/stop timer controller driving a loadable up/down counter
// Optional expiry counter port exp_cnt_o enabled by COUNTER_32_CTRL_EXPCNT_EN.
module counter_32_ctrl
  import counter_32_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
`ifdef COUNTER_32_CTRL_EXPCNT_EN
  , parameter int unsigned ECNT_W = 8
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              dir_i,
  input  logic              periodic_i,
  input  logic [WIDTH-1:0]  reload_i,
  input  logic [WIDTH-1:0]  cnt_in_i,
  input  logic              rc_in_i,
  input  logic              irq_clr_i,
  output logic              cnt_s_o,
  output logic              cnt_load_o,
  output logic [WIDTH-1:0]  cnt_pdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              irq_o
`ifdef COUNTER_32_CTRL_EXPCNT_EN
  , output logic [ECNT_W-1:0] exp_cnt_o
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             dir_q, dir_d;
  logic             per_q, per_d;
  logic             counted_q, counted_d;
  logic [WIDTH-1:0] term;
  logic             rc_valid;

  assign term     = dir_q ? TERM_UP : TERM_DN;
  // Rc is held across a load, so only trust it after a real count step.
  assign rc_valid = rc_in_i & counted_q & (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    reload_d    = reload_q;
    dir_d       = dir_q;
    per_d       = per_q;
    cnt_load_o  = 1'b1;
    cnt_pdata_o = cnt_in_i;
    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          reload_d = reload_i;
          dir_d    = dir_i;
          per_d    = periodic_i;
          state_d  = ARM;
        end
      end
      ARM: begin
        cnt_pdata_o = reload_q;
        state_d     = stop_i ? IDLE : RUN;
      end
      RUN: begin
        if (stop_i) begin
          cnt_pdata_o = rc_valid ? term : cnt_in_i;
          state_d     = IDLE;
        end else if (start_i) begin
          reload_d    = reload_i;
          dir_d       = dir_i;
          per_d       = periodic_i;
          cnt_pdata_o = reload_i;
          state_d     = ARM;
        end else if (rc_valid) begin
          cnt_pdata_o = per_q ? reload_q : term;
          state_d     = per_q ? ARM : IDLE;
        end else begin
          cnt_load_o = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign counted_d = ~cnt_load_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      reload_q  <= '0;
      dir_q     <= 1'b0;
      per_q     <= 1'b0;
      counted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reload_q  <= reload_d;
      dir_q     <= dir_d;
      per_q     <= per_d;
      counted_q <= counted_d;
    end
  end

  assign cnt_s_o = dir_q;
  assign busy_o  = (state_q == ARM) || (state_q == RUN);

  counter_32_ctrl_irq
`ifdef COUNTER_32_CTRL_EXPCNT_EN
  #(.ECNT_W(ECNT_W))
`endif
  u_irq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rc_valid_i (rc_valid),
    .irq_clr_i  (irq_clr_i),
`ifdef COUNTER_32_CTRL_EXPCNT_EN
    .start_i    (start_i),
    .exp_cnt_o  (exp_cnt_o),
`endif
    .done_o     (done_o),
    .irq_o      (irq_o)
  );

endmodule

// File: tb/tb_counter_32_ctrl.sv
// tb/tb_counter_32_ctrl.sv - bench for counter_32_ctrl with counter model and timer reference
// Exercises exp_cnt_o as well when COUNTER_32_CTRL_EXPCNT_EN is defined.
module tb_counter_32_ctrl;

  logic        clk = 1'b0, rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, dir = 1'b0, periodic = 1'b0, irq_clr = 1'b0;
  logic [31:0] reload = '0;
  logic [31:0] cnt = '0;
  logic        rc = 1'b0;
  logic        cnt_s, cnt_load, busy, done, irq;
  logic [31:0] cnt_pdata;
`ifdef COUNTER_32_CTRL_EXPCNT_EN
  logic [7:0]  exp_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  counter_32_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .stop_i      (stop),
    .dir_i       (dir),
    .periodic_i  (periodic),
    .reload_i    (reload),
    .cnt_in_i    (cnt),
    .rc_in_i     (rc),
    .irq_clr_i   (irq_clr),
    .cnt_s_o     (cnt_s),
    .cnt_load_o  (cnt_load),
    .cnt_pdata_o (cnt_pdata),
    .busy_o      (busy),
    .done_o      (done),
    .irq_o       (irq)
`ifdef COUNTER_32_CTRL_EXPCNT_EN
    , .exp_cnt_o (exp_cnt)
`endif
  );

  // The 32-bit counter the controller drives.
  always @(posedge clk) begin
    if (cnt_load) begin
      cnt <= cnt_pdata;
    end else begin
      rc  <= cnt_s ? (cnt == 32'hFFFF_FFFF) : (cnt == 32'h0);
      cnt <= cnt_s ? cnt + 32'd1 : cnt - 32'd1;
    end
  end

  // Timer reference: tracks how many run cycles remain until the counter wraps.
  int          m_phase = 0;   // 0 idle, 1 arm, 2 run
  logic [31:0] m_r = '0, m_cnt = '0, m_term, m_nxt;
  logic        m_dir = 1'b0, m_per = 1'b0, m_done = 1'b0, m_irq = 1'b0, m_exp_now;
  logic [63:0] m_k = '0;
  int          m_exp = 0, m_ph;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_done = 1'b0; m_irq = 1'b0; m_exp = 0;
      m_r = '0; m_dir = 1'b0; m_per = 1'b0; m_k = '0;
    end else begin
      m_term    = m_dir ? 32'hFFFF_FFFF : 32'h0;
      m_exp_now = (m_phase == 2) && (m_k == {32'd0, (m_dir ? ~m_r : m_r)} + 64'd2);
      m_nxt     = m_cnt;
      m_ph      = m_phase;
      if (m_phase == 0) begin
        if (start && !stop) begin
          m_r = reload; m_dir = dir; m_per = periodic; m_ph = 1;
        end
      end else if (m_phase == 1) begin
        m_nxt = m_r; m_k = 64'd1; m_ph = stop ? 0 : 2;
      end else begin
        if (stop) begin
          m_nxt = m_exp_now ? m_term : m_cnt; m_ph = 0;
        end else if (start) begin
          m_r = reload; m_dir = dir; m_per = periodic; m_nxt = reload; m_ph = 1;
        end else if (m_exp_now) begin
          m_nxt = m_per ? m_r : m_term; m_ph = m_per ? 1 : 0;
        end else begin
          m_nxt = m_dir ? m_cnt + 32'd1 : m_cnt - 32'd1; m_k = m_k + 64'd1;
        end
      end
      m_irq = m_exp_now | (m_irq & ~irq_clr);
      m_done = m_exp_now;
      if (start) m_exp = 0;
      else if (m_exp_now && m_exp < 255) m_exp = m_exp + 1;
      m_cnt = m_nxt;
      m_phase = m_ph;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, m_phase != 0});
      check("model_done", {31'd0, done}, {31'd0, m_done});
      check("model_irq", {31'd0, irq}, {31'd0, m_irq});
      check("model_cnt", cnt, m_cnt);
`ifdef COUNTER_32_CTRL_EXPCNT_EN
      check("model_exp_cnt", {24'd0, exp_cnt}, m_exp);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(input logic d, input logic p, input logic [31:0] r);
    dir = d; periodic = p; reload = r; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  int d_cnt;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    tick(1);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_load", {31'd0, cnt_load}, 32'd1);

    // Down, periodic, reload 3: wrap at S+6, done at S+7, S+13, S+19.
    tick(1); go(1'b0, 1'b1, 32'd3);
    tick(5); @(negedge clk);
    check("t1_wrap_cnt", cnt, 32'hFFFF_FFFF);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick(1); @(negedge clk);
    check("t1_done1", {31'd0, done}, 32'd1);
    check("t1_irq", {31'd0, irq}, 32'd1);
    check("t1_cnt_arm", cnt, 32'd3);
    tick(5); @(negedge clk);
    check("t1_no_done", {31'd0, done}, 32'd0);
    tick(1); @(negedge clk);
    check("t1_done2", {31'd0, done}, 32'd1);
    tick(6); @(negedge clk);
    check("t1_done3", {31'd0, done}, 32'd1);
    tick(1); stop = 1'b1; @(negedge clk);
    check("t1_stop_load", {31'd0, cnt_load}, 32'd1);
    tick(1); stop = 1'b0; @(negedge clk);
    check("t1_stop_busy", {31'd0, busy}, 32'd0);
    check("t1_stop_cnt", cnt, 32'd3);

    // Up one-shot from FFFFFFFD: single expiry, then frozen at all-ones.
    tick(1); go(1'b1, 1'b0, 32'hFFFF_FFFD);
    tick(3); @(negedge clk);
    check("t2_top", cnt, 32'hFFFF_FFFF);
    tick(1); @(negedge clk);
    check("t2_wrapped", cnt, 32'd0);
    tick(1); @(negedge clk);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_idle", {31'd0, busy}, 32'd0);
    d_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1); @(negedge clk);
      if (done) d_cnt++;
    end
    check("t2_hold_cnt", cnt, 32'hFFFF_FFFF);
    check("t2_extra_done", d_cnt, 32'd0);

    // Stale Rc held at 1 through ARM must not expire; first done at S+9.
    tick(1); go(1'b0, 1'b0, 32'd5);
    d_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) d_cnt++;
      tick(1);
    end
    @(negedge clk);
    check("t3_early_done", d_cnt, 32'd0);
    check("t3_done", {31'd0, done}, 32'd1);

    // Stop at cnt=10 while counting down from 12.
    tick(1); go(1'b0, 1'b0, 32'd12);
    tick(3); stop = 1'b1; @(negedge clk);
    check("t4_load", {31'd0, cnt_load}, 32'd1);
    check("t4_cnt_at_stop", cnt, 32'd10);
    tick(1); stop = 1'b0; @(negedge clk);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_frozen", cnt, 32'd10);
    tick(3); @(negedge clk);
    check("t4_still_frozen", cnt, 32'd10);

    // start and stop together in IDLE: stop wins.
    tick(1); start = 1'b1; stop = 1'b1;
    tick(1); start = 1'b0; stop = 1'b0; @(negedge clk);
    check("ss_busy", {31'd0, busy}, 32'd0);

    // irq_clr coincident with expiry keeps irq; alone it clears.
    tick(1); irq_clr = 1'b1;
    tick(1); irq_clr = 1'b0; @(negedge clk);
    check("t5_pre_clr", {31'd0, irq}, 32'd0);
    tick(1); go(1'b0, 1'b0, 32'd2);
    tick(4); irq_clr = 1'b1;
    tick(1); @(negedge clk);
    check("t5_irq_kept", {31'd0, irq}, 32'd1);
    check("t5_done", {31'd0, done}, 32'd1);
    tick(1); irq_clr = 1'b0; @(negedge clk);
    check("t5_irq_cleared", {31'd0, irq}, 32'd0);

    // Async reset mid-RUN at cnt=7.
    tick(1); go(1'b0, 1'b1, 32'd10);
    tick(4); rst = 1'b1; #1;
    check("t6_busy_now", {31'd0, busy}, 32'd0);
    check("t6_load_now", {31'd0, cnt_load}, 32'd1);
    @(negedge clk);
    check("t6_cnt", cnt, 32'd7);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_irq", {31'd0, irq}, 32'd0);
    tick(2); rst = 1'b0; @(negedge clk);
    check("t6_cnt_after", cnt, 32'd7);
    check("t6_busy_after", {31'd0, busy}, 32'd0);
`ifdef COUNTER_32_CTRL_EXPCNT_EN
    check("t6_exp_cnt", {24'd0, exp_cnt}, 32'd0);
`endif
    tick(3);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
